// File: rtl/riscv_alu_arbiter.sv
// rtl/riscv_alu_arbiter.sv - shares one riscv_alu between two cores, one op in flight
// Optional round-robin tie-break under `ALU_ARB_ROUND_ROBIN_EN (fixed priority to core 0 otherwise).

module riscv_alu (
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] alu_a_i,
  input  logic [31:0] alu_b_i,
  output logic [31:0] alu_p_o
);
  localparam logic [3:0] ALU_SHIFTL           = 4'd1;
  localparam logic [3:0] ALU_SHIFTR           = 4'd2;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd3;
  localparam logic [3:0] ALU_ADD              = 4'd4;
  localparam logic [3:0] ALU_SUB              = 4'd6;
  localparam logic [3:0] ALU_AND              = 4'd7;
  localparam logic [3:0] ALU_OR               = 4'd8;
  localparam logic [3:0] ALU_XOR              = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd10;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd11;

  // Unknown op codes (including ALU_NONE) pass operand A through.
  always_comb begin
    alu_p_o = alu_a_i;
    case (alu_op_i)
      ALU_SHIFTL:           alu_p_o = alu_a_i << alu_b_i[4:0];
      ALU_SHIFTR:           alu_p_o = alu_a_i >> alu_b_i[4:0];
      ALU_SHIFTR_ARITH:     alu_p_o = $unsigned($signed(alu_a_i) >>> alu_b_i[4:0]);
      ALU_ADD:              alu_p_o = alu_a_i + alu_b_i;
      ALU_SUB:              alu_p_o = alu_a_i - alu_b_i;
      ALU_AND:              alu_p_o = alu_a_i & alu_b_i;
      ALU_OR:               alu_p_o = alu_a_i | alu_b_i;
      ALU_XOR:              alu_p_o = alu_a_i ^ alu_b_i;
      ALU_LESS_THAN:        alu_p_o = {31'b0, (alu_a_i < alu_b_i)};
      ALU_LESS_THAN_SIGNED: alu_p_o = {31'b0, ($signed(alu_a_i) < $signed(alu_b_i))};
      default:              alu_p_o = alu_a_i;
    endcase
  end
endmodule

module riscv_alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [3:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  output logic        req0_ready_o,
  output logic        resp0_valid_o,
  output logic [31:0] resp0_result_o,
  input  logic        resp0_ready_i,
  input  logic        req1_valid_i,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        req1_ready_o,
  output logic        resp1_valid_o,
  output logic [31:0] resp1_result_o,
  input  logic        resp1_ready_i,
  output logic        busy_o
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic [31:0] alu_result;
  logic        tie_pick;
  logic        winner;
  logic        can_accept;
  logic        handshake;
  logic        resp_ready_sel;
  logic        in_resp;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;

  assign tie_pick = ~last_q;
  assign last_d   = handshake ? winner : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign tie_pick = 1'b0;
`endif

  // Winner is meaningful only when at least one core is requesting.
  assign winner     = (req0_valid_i && req1_valid_i) ? tie_pick : req1_valid_i;
  assign can_accept = (state_q == ST_IDLE) && !rst_i;

  assign req0_ready_o = can_accept && req0_valid_i && !winner;
  assign req1_ready_o = can_accept && req1_valid_i && winner;
  assign handshake    = req0_ready_o || req1_ready_o;

  riscv_alu u_alu (
    .alu_op_i (op_q),
    .alu_a_i  (a_q),
    .alu_b_i  (b_q),
    .alu_p_o  (alu_result)
  );

  assign resp_ready_sel = owner_q ? resp1_ready_i : resp0_ready_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_EXEC;
          owner_d = winner;
          op_d    = winner ? req1_op_i : req0_op_i;
          a_d     = winner ? req1_a_i  : req0_a_i;
          b_d     = winner ? req1_b_i  : req0_b_i;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // The non-owner always sees a zero result.
  assign in_resp        = (state_q == ST_RESP);
  assign resp0_valid_o  = in_resp && !owner_q;
  assign resp1_valid_o  = in_resp && owner_q;
  assign resp0_result_o = owner_q ? 32'd0 : result_q;
  assign resp1_result_o = owner_q ? result_q : 32'd0;
  assign busy_o         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// tb/tb_riscv_alu_arbiter.sv - self-checking bench for riscv_alu_arbiter
// Expectations follow the ALU_ARB_ROUND_ROBIN_EN setting of the build.

module tb_riscv_alu_arbiter;
  localparam logic [3:0] OP_SHL = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_SRA = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_LTS = 4'd11;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        req0_ready_o, req1_ready_o;
  logic        resp0_valid_o, resp1_valid_o;
  logic [31:0] resp0_result_o, resp1_result_o;
  logic        resp0_ready_i, resp1_ready_i;
  logic        busy_o;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] want0, want1;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          grants[$];

  riscv_alu_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req0_valid_i   (req0_valid_i),
    .req0_op_i      (req0_op_i),
    .req0_a_i       (req0_a_i),
    .req0_b_i       (req0_b_i),
    .req0_ready_o   (req0_ready_o),
    .resp0_valid_o  (resp0_valid_o),
    .resp0_result_o (resp0_result_o),
    .resp0_ready_i  (resp0_ready_i),
    .req1_valid_i   (req1_valid_i),
    .req1_op_i      (req1_op_i),
    .req1_a_i       (req1_a_i),
    .req1_b_i       (req1_b_i),
    .req1_ready_o   (req1_ready_o),
    .resp1_valid_o  (resp1_valid_o),
    .resp1_result_o (resp1_result_o),
    .resp1_ready_i  (resp1_ready_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: expected result queued at each request handshake, checked at response handshake.
  always @(negedge clk_i) begin
    logic [31:0] e;
    #2;
    if (rst_i) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (req0_valid_i && req0_ready_o) begin exp0.push_back(want0); grants.push_back(0); end
      if (req1_valid_i && req1_ready_o) begin exp1.push_back(want1); grants.push_back(1); end
      if (resp0_valid_o && resp1_valid_o) begin
        n_total++;
        $display("FAIL sb_both_valid: resp0_valid=1 resp1_valid=1, want at most one");
      end
      if (resp0_valid_o && resp0_ready_i) begin
        n_total++;
        if (exp0.size() == 0) begin
          $display("FAIL sb_resp0: unexpected response %h, want none", resp0_result_o);
        end else begin
          e = exp0.pop_front();
          if (resp0_result_o !== e) $display("FAIL sb_resp0: got %h want %h", resp0_result_o, e);
          else n_pass++;
        end
      end
      if (resp1_valid_o && resp1_ready_i) begin
        n_total++;
        if (exp1.size() == 0) begin
          $display("FAIL sb_resp1: unexpected response %h, want none", resp1_result_o);
        end else begin
          e = exp1.pop_front();
          if (resp1_result_o !== e) $display("FAIL sb_resp1: got %h want %h", resp1_result_o, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    grants.delete();
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o} !== 5'b0)
      $display("FAIL reset_ctrl: rdy0=%b rdy1=%b rv0=%b rv1=%b busy=%b want all 0",
               req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o);
    else n_pass++;
    n_total++;
    if (resp0_result_o !== 32'd0 || resp1_result_o !== 32'd0)
      $display("FAIL reset_result: r0=%h r1=%h want 0", resp0_result_o, resp1_result_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o, busy_o} !== 3'b0)
      $display("FAIL idle_no_req: rdy0=%b rdy1=%b busy=%b want 0", req0_ready_o, req1_ready_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    do_reset();
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    drive0(1'b1, OP_ADD, 32'd5, 32'd7);
    want0 = 32'h0000000C;
    #1;
    n_total++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL single_grant: rdy0=%b rdy1=%b busy=%b want 1 0 0", req0_ready_o, req1_ready_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    #1;
    n_total++;
    if (busy_o !== 1'b1 || resp0_valid_o !== 1'b0)
      $display("FAIL single_exec: busy=%b rv0=%b want 1 0", busy_o, resp0_valid_o);
    else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++;
    if (resp0_valid_o !== 1'b1 || resp0_result_o !== 32'h0000000C || busy_o !== 1'b1)
      $display("FAIL single_resp: rv0=%b res=%h busy=%b want 1 0000000c 1", resp0_valid_o, resp0_result_o, busy_o);
    else n_pass++;
    n_total++;
    if (resp1_valid_o !== 1'b0 || resp1_result_o !== 32'd0)
      $display("FAIL single_nonowner: rv1=%b r1=%h want 0 0", resp1_valid_o, resp1_result_o);
    else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++;
    if (busy_o !== 1'b0 || resp0_valid_o !== 1'b0)
      $display("FAIL single_done: busy=%b rv0=%b want 0 0", busy_o, resp0_valid_o);
    else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_contention();
    logic both_rdy, r1_seen, h0, seen_hs, got;
    int   bad;
    do_reset();
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    drive0(1'b1, OP_SUB, 32'd3, 32'd5);
    want0 = 32'hFFFFFFFE;
    drive1(1'b1, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F);
    want1 = 32'hF00FF00F;
    both_rdy = 1'b0;
    r1_seen  = 1'b0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (req0_ready_o && req1_ready_o) both_rdy = 1'b1;
      if (req1_ready_o) r1_seen = 1'b1;
      @(negedge clk_i);
    end
    n_total++;
    if (both_rdy) $display("FAIL contention_one_ready: both readies high, want at most one");
    else n_pass++;
    bad = 0;
    for (int i = 0; i < grants.size(); i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (grants[i] != (i % 2)) bad++;
`else
      if (grants[i] != 0) bad++;
`endif
    end
    n_total++;
    if (grants.size() != 8 || bad != 0)
      $display("FAIL contention_order: grants=%0d wrong=%0d want 8 grants 0 wrong", grants.size(), bad);
    else n_pass++;
`ifndef ALU_ARB_ROUND_ROBIN_EN
    n_total++;
    if (r1_seen) $display("FAIL fixed_starve: req1_ready seen=1 want 0");
    else n_pass++;
`endif
    seen_hs = 1'b0;
    for (int c = 0; c < 8 && !seen_hs; c++) begin
      #1;
      h0 = req0_ready_o;
      @(negedge clk_i);
      if (h0) begin req0_valid_i = 1'b0; seen_hs = 1'b1; end
    end
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (!busy_o) begin
        got = 1'b1;
        n_total++;
        if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0)
          $display("FAIL contention_drop: rdy1=%b rdy0=%b want 1 0", req1_ready_o, req0_ready_o);
        else n_pass++;
      end
      @(negedge clk_i);
    end
    req1_valid_i = 1'b0;
    n_total++;
    if (!seen_hs || !got) $display("FAIL contention_timeout: hs=%b idle=%b want 1 1", seen_hs, got);
    else n_pass++;
    repeat (4) @(negedge clk_i);
    n_total++;
    if (exp0.size() != 0 || exp1.size() != 0)
      $display("FAIL contention_drain: pending %0d/%0d want 0/0", exp0.size(), exp1.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b0;
    drive1(1'b1, OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C);
    want1 = 32'h30303030;
    #1;
    n_total++;
    if (req1_ready_o !== 1'b1) $display("FAIL bp_grant1: rdy1=%b want 1", req1_ready_o);
    else n_pass++;
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    want0 = 32'd3;
    @(negedge clk_i);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if ({resp1_valid_o, resp1_result_o, busy_o, req0_ready_o} !== {1'b1, 32'h30303030, 1'b1, 1'b0})
        $display("FAIL bp_hold: rv1=%b r1=%h busy=%b rdy0=%b want 1 30303030 1 0",
                 resp1_valid_o, resp1_result_o, busy_o, req0_ready_o);
      else n_pass++;
      @(negedge clk_i);
    end
    resp1_ready_i = 1'b1;
    #1;
    n_total++;
    if (resp1_valid_o !== 1'b1 || req0_ready_o !== 1'b0)
      $display("FAIL bp_release: rv1=%b rdy0=%b want 1 0", resp1_valid_o, req0_ready_o);
    else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++;
    if (req0_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL bp_next_grant: rdy0=%b busy=%b want 1 0", req0_ready_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_total++;
    if (exp0.size() != 0 || exp1.size() != 0)
      $display("FAIL bp_drain: pending %0d/%0d want 0/0", exp0.size(), exp1.size());
    else n_pass++;
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  ops [7];
    logic [31:0] as [7];
    logic [31:0] bs [7];
    logic [31:0] rs [7];
    logic        hs, got;
    ops = '{OP_SRA, OP_SHR, OP_LTS, OP_LT, OP_SHL, 4'hF, OP_SUB};
    as  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hDEADBEEF, 32'h00000000};
    bs  = '{32'd4, 32'd4, 32'd1, 32'd1, 32'd31, 32'd9, 32'd1};
    rs  = '{32'hF8000000, 32'h08000000, 32'h00000001, 32'h00000000, 32'h80000000, 32'hDEADBEEF, 32'hFFFFFFFF};
    do_reset();
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive1(1'b1, ops[k], as[k], bs[k]);
      want1 = rs[k];
      hs  = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        #1;
        if (req1_ready_o) hs = 1'b1;
        if (resp1_valid_o) begin
          got = 1'b1;
          n_total++;
          if (resp1_result_o !== rs[k])
            $display("FAIL op_%0d: op=%h got %h want %h", k, ops[k], resp1_result_o, rs[k]);
          else n_pass++;
        end
        @(negedge clk_i);
        if (hs) req1_valid_i = 1'b0;
      end
      if (!got) begin
        n_total++;
        $display("FAIL op_%0d_timeout: response seen=0 want 1", k);
      end
    end
  endtask

  task automatic test_reset_midop(input int in_resp);
    logic seen, h0, h1;
    do_reset();
    resp0_ready_i = 1'b0;
    resp1_ready_i = 1'b1;
    drive0(1'b1, OP_ADD, 32'd1, 32'd1);
    want0 = 32'd2;
    #1;
    n_total++;
    if (req0_ready_o !== 1'b1) $display("FAIL rst%0d_grant: rdy0=%b want 1", in_resp, req0_ready_o);
    else n_pass++;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    if (in_resp != 0) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o} !== 5'b0 ||
        resp0_result_o !== 32'd0 || resp1_result_o !== 32'd0)
      $display("FAIL rst%0d_outputs: rv0=%b busy=%b r0=%h r1=%h want 0 0 0 0",
               in_resp, resp0_valid_o, busy_o, resp0_result_o, resp1_result_o);
    else n_pass++;
    @(negedge clk_i);
    resp0_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (resp0_valid_o || resp1_valid_o) seen = 1'b1;
      @(negedge clk_i);
    end
    n_total++;
    if (seen) $display("FAIL rst%0d_aborted: response seen=1 want 0", in_resp);
    else n_pass++;
    drive0(1'b1, OP_ADD, 32'd10, 32'd20);
    want0 = 32'd30;
    drive1(1'b1, OP_SUB, 32'd0, 32'd1);
    want1 = 32'hFFFFFFFF;
    #1;
    n_total++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0)
      $display("FAIL rst%0d_tie: rdy0=%b rdy1=%b want 1 0", in_resp, req0_ready_o, req1_ready_o);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      h0 = req0_ready_o;
      h1 = req1_ready_o;
      @(negedge clk_i);
      if (h0) req0_valid_i = 1'b0;
      if (h1) req1_valid_i = 1'b0;
      #1;
    end
    @(negedge clk_i);
    n_total++;
    if (exp0.size() != 0 || exp1.size() != 0 || req1_valid_i !== 1'b0)
      $display("FAIL rst%0d_drain: pending %0d/%0d v1=%b want 0/0 0", in_resp, exp0.size(), exp1.size(), req1_valid_i);
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1;
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    want0 = 32'd0;
    want1 = 32'd0;
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    drive1(1'b1, OP_ADD, 32'd3, 32'd4);
    @(negedge clk_i);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_shift_cmp();
    test_reset_midop(0);
    test_reset_midop(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
